rf_port_arbiter: RTL and testbench

Shares the single register-file access port (two read addresses, one write port) between two requesters: requester A (core pipeline) and requester B (RSA coprocessor sequencer). It arbitrates per operation with round-robin fairness and an optional B bus lock for multi-word sequences. It drives the regfile control signals in the correct phase: write on the falling edge, registered read on the rising edge. It returns read data and a completion pulse to the winning requester.

---
 rtl/rf_port_arbiter_if.sv | 42 ++++
 rtl/rf_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_rf_port_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_port_arbiter_if.sv
// rf_port_arbiter_if
//   Requester-side bundle for one client of the shared register-file port.
//   Each requester (core pipeline A, RSA sequencer B) gets one instance.
//
//   req     requester -> arbiter  request one operation
//   we      requester -> arbiter  1 = write, 0 = read
//   src1    requester -> arbiter  first read address
//   src2    requester -> arbiter  second read address
//   dest    requester -> arbiter  write address
//   wdata   requester -> arbiter  write data
//   gnt     arbiter -> requester  one-cycle pulse, operation accepted
//   done    arbiter -> requester  one-cycle pulse, operation complete
//   rdata1  arbiter -> requester  read result for src1
//   rdata2  arbiter -> requester  read result for src2
//
//   Modport master is the requester side, slave is the arbiter side.

interface rf_port_arbiter_if #(
    parameter int REG_ADDR = 3,
    parameter int REG_SIZE = 16
);
    logic                req;
    logic                we;
    logic [REG_ADDR-1:0] src1;
    logic [REG_ADDR-1:0] src2;
    logic [REG_ADDR-1:0] dest;
    logic [REG_SIZE-1:0] wdata;
    logic                gnt;
    logic                done;
    logic [REG_SIZE-1:0] rdata1;
    logic [REG_SIZE-1:0] rdata2;

    modport master (
        output req, we, src1, src2, dest, wdata,
        input  gnt, done, rdata1, rdata2
    );

    modport slave (
        input  req, we, src1, src2, dest, wdata,
        output gnt, done, rdata1, rdata2
    );
endinterface

// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter
//   Shares the single register-file port (two read addresses, one write)
//   between requester A (core pipeline) and requester B (RSA sequencer).
//   Operations are arbitrated round-robin, one at a time; B can hold the
//   port across a multi-word sequence with b_lock. Writes land on the
//   falling edge of the ISSUE cycle, reads are registered by the regfile
//   on the rising edge that ends ISSUE and are copied out in CAPTURE.
//
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-low reset
//   a, b         requester bundles (rf_port_arbiter_if.slave)
//   b_lock       B keeps the port while set, sampled at arbitration
//   rf_src1/2    regfile read addresses
//   rf_dest      regfile write address
//   rf_writeVal  regfile write data
//   rf_writeEn   regfile write enable (ISSUE cycle of a write only)
//   rf_readEn    regfile read enable (ISSUE cycle of a read only)
//   rf_reg1/2    regfile read outputs

module rf_port_arbiter #(
    parameter int REG_ADDR = 3,
    parameter int REG_SIZE = 16
) (
    input  logic                clk,
    input  logic                rst,
    rf_port_arbiter_if.slave    a,
    rf_port_arbiter_if.slave    b,
    input  logic                b_lock,
    output logic [REG_ADDR-1:0] rf_src1,
    output logic [REG_ADDR-1:0] rf_src2,
    output logic [REG_ADDR-1:0] rf_dest,
    output logic [REG_SIZE-1:0] rf_writeVal,
    output logic                rf_writeEn,
    output logic                rf_readEn,
    input  logic [REG_SIZE-1:0] rf_reg1,
    input  logic [REG_SIZE-1:0] rf_reg2
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t              state;
    state_t              state_next;

    logic                last_b;
    logic                served;
    logic                cmd_b;
    logic                cmd_we;
    logic [REG_ADDR-1:0] cmd_src1;
    logic [REG_ADDR-1:0] cmd_src2;
    logic [REG_ADDR-1:0] cmd_dest;
    logic [REG_SIZE-1:0] cmd_wdata;

    logic                a_done_q;
    logic                b_done_q;
    logic [REG_SIZE-1:0] a_rdata1_q;
    logic [REG_SIZE-1:0] a_rdata2_q;
    logic [REG_SIZE-1:0] b_rdata1_q;
    logic [REG_SIZE-1:0] b_rdata2_q;

    logic                arb_slot;
    logic                lock_active;
    logic                win_a;
    logic                win_b;

    // Arbitration and next state. The lock only applies once B has actually
    // won an operation; last_b alone resets to B so it cannot be used here.
    // Under the lock, A is held off even when B is not requesting.
    always_comb begin
        arb_slot    = (state == IDLE) || (state == CAPTURE);
        lock_active = served && last_b && b_lock;
        win_a       = 1'b0;
        win_b       = 1'b0;
        state_next  = IDLE;

        if (arb_slot) begin
            if (lock_active) begin
                win_b = b.req;
            end else if (a.req && b.req) begin
                win_a = last_b;
                win_b = !last_b;
            end else begin
                win_a = a.req;
                win_b = b.req;
            end
        end

        case (state)
            IDLE:    state_next = (win_a || win_b) ? ISSUE : IDLE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = (win_a || win_b) ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus command registers latched from the winner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            served    <= 1'b0;
            cmd_b     <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_src1  <= '0;
            cmd_src2  <= '0;
            cmd_dest  <= '0;
            cmd_wdata <= '0;
        end else begin
            state <= state_next;
            if (win_a || win_b) begin
                last_b    <= win_b;
                served    <= 1'b1;
                cmd_b     <= win_b;
                cmd_we    <= win_b ? b.we    : a.we;
                cmd_src1  <= win_b ? b.src1  : a.src1;
                cmd_src2  <= win_b ? b.src2  : a.src2;
                cmd_dest  <= win_b ? b.dest  : a.dest;
                cmd_wdata <= win_b ? b.wdata : a.wdata;
            end
        end
    end

    // Completion: done follows CAPTURE by one edge so it lines up with the
    // freshly copied read data. Writes pulse done but leave rdata alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_done_q   <= 1'b0;
            b_done_q   <= 1'b0;
            a_rdata1_q <= '0;
            a_rdata2_q <= '0;
            b_rdata1_q <= '0;
            b_rdata2_q <= '0;
        end else begin
            a_done_q <= (state == CAPTURE) && !cmd_b;
            b_done_q <= (state == CAPTURE) && cmd_b;
            if ((state == CAPTURE) && !cmd_we) begin
                if (cmd_b) begin
                    b_rdata1_q <= rf_reg1;
                    b_rdata2_q <= rf_reg2;
                end else begin
                    a_rdata1_q <= rf_reg1;
                    a_rdata2_q <= rf_reg2;
                end
            end
        end
    end

    // Grants and enables are decoded from state so a reset kills them
    // immediately, which also suppresses a write not yet at its falling edge.
    assign a.gnt       = (state == ISSUE) && !cmd_b;
    assign b.gnt       = (state == ISSUE) && cmd_b;
    assign rf_writeEn  = (state == ISSUE) && cmd_we;
    assign rf_readEn   = (state == ISSUE) && !cmd_we;

    assign rf_src1     = cmd_src1;
    assign rf_src2     = cmd_src2;
    assign rf_dest     = cmd_dest;
    assign rf_writeVal = cmd_wdata;

    assign a.done      = a_done_q;
    assign b.done      = b_done_q;
    assign a.rdata1    = a_rdata1_q;
    assign a.rdata2    = a_rdata2_q;
    assign b.rdata1    = b_rdata1_q;
    assign b.rdata2    = b_rdata2_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb_rf_port_arbiter
//   Directed bench for rf_port_arbiter. A behavioural regfile (write on the
//   falling edge, registered read on the rising edge) sits on the rf_* side.
//   All drives and samples happen 1 time unit after the rising edge.

module tb_rf_port_arbiter;

    logic        clk;
    logic        rst;
    logic        b_lock;
    logic [2:0]  rf_src1;
    logic [2:0]  rf_src2;
    logic [2:0]  rf_dest;
    logic [15:0] rf_writeVal;
    logic        rf_writeEn;
    logic        rf_readEn;
    logic [15:0] rf_reg1;
    logic [15:0] rf_reg2;
    logic [15:0] mem [8];

    int compared;
    int mismatched;

    rf_port_arbiter_if #(.REG_ADDR(3), .REG_SIZE(16)) a_if ();
    rf_port_arbiter_if #(.REG_ADDR(3), .REG_SIZE(16)) b_if ();

    rf_port_arbiter #(.REG_ADDR(3), .REG_SIZE(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a_if),
        .b           (b_if),
        .b_lock      (b_lock),
        .rf_src1     (rf_src1),
        .rf_src2     (rf_src2),
        .rf_dest     (rf_dest),
        .rf_writeVal (rf_writeVal),
        .rf_writeEn  (rf_writeEn),
        .rf_readEn   (rf_readEn),
        .rf_reg1     (rf_reg1),
        .rf_reg2     (rf_reg2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile model: falling-edge write, rising-edge registered read.
    always @(negedge clk) begin
        if (rf_writeEn) mem[rf_dest] <= rf_writeVal;
    end

    always @(posedge clk) begin
        if (rf_readEn) begin
            rf_reg1 <= mem[rf_src1];
            rf_reg2 <= mem[rf_src2];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit is_b, input logic req, input logic we,
                                 input logic [2:0] s1, input logic [2:0] s2,
                                 input logic [2:0] d, input logic [15:0] wd);
        if (is_b) begin
            b_if.req = req; b_if.we = we; b_if.src1 = s1;
            b_if.src2 = s2; b_if.dest = d; b_if.wdata = wd;
        end else begin
            a_if.req = req; a_if.we = we; a_if.src1 = s1;
            a_if.src2 = s2; a_if.dest = d; a_if.wdata = wd;
        end
    endtask

    // One isolated operation with bounded waits for gnt and done.
    task automatic doOp(input bit is_b, input logic we, input logic [2:0] s1,
                        input logic [2:0] s2, input logic [2:0] d,
                        input logic [15:0] wd, input string tag);
        logic seen;
        applyStimulus(is_b, 1'b1, we, s1, s2, d, wd);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            seen = is_b ? b_if.gnt : a_if.gnt;
        end
        applyStimulus(is_b, 1'b0, we, s1, s2, d, wd);
        checkOutput({tag, "_gnt"}, 32'(seen), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            seen = is_b ? b_if.done : a_if.done;
        end
        checkOutput({tag, "_done"}, 32'(seen), 32'd1);
        step();
    endtask

    logic [1:0] exp_gnt  [8];
    logic [1:0] exp_done [8];

    initial begin
        compared   = 0;
        mismatched = 0;
        rf_reg1    = '0;
        rf_reg2    = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;

        // Reset held with random requester activity: everything stays 0.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
                          3'($urandom), 16'($urandom));
            applyStimulus(1, 1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
                          3'($urandom), 16'($urandom));
            b_lock = 1'($urandom);
            step();
            checkOutput("rst_ctrl", 32'({a_if.gnt, b_if.gnt, a_if.done, b_if.done,
                                         rf_writeEn, rf_readEn}), 32'd0);
            checkOutput("rst_data", 32'({rf_src1, rf_src2, rf_dest,
                                         a_if.rdata1 | a_if.rdata2 | b_if.rdata1 |
                                         b_if.rdata2 | rf_writeVal}), 32'd0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        b_lock = 1'b0;
        rst    = 1'b1;

        // A writes R3=0x1234, then reads R3/R0 back-to-back.
        applyStimulus(0, 1, 1, 0, 0, 3'd3, 16'h1234);
        step();
        checkOutput("t1_a_gnt", 32'(a_if.gnt), 32'd1);
        checkOutput("t1_wr_en", 32'({rf_writeEn, rf_readEn}), 32'b10);
        checkOutput("t1_rf_cmd", 32'({rf_dest, rf_writeVal}), {13'd0, 3'd3, 16'h1234});
        applyStimulus(0, 1, 0, 3'd3, 3'd0, 0, 0);
        step();
        checkOutput("t1_capture", 32'({a_if.gnt, a_if.done, rf_writeEn, rf_readEn}), 32'd0);
        step();
        checkOutput("t1_done_w", 32'({a_if.gnt, a_if.done, rf_readEn}), 32'b111);
        checkOutput("t1_rd_addr", 32'({rf_src1, rf_src2}), {26'd0, 3'd3, 3'd0});
        applyStimulus(0, 0, 0, 3'd3, 3'd0, 0, 0);
        step();
        checkOutput("t1_done_gap", 32'(a_if.done), 32'd0);
        step();
        checkOutput("t1_done_r", 32'(a_if.done), 32'd1);
        checkOutput("t1_rdata", {a_if.rdata1, a_if.rdata2}, {16'h1234, 16'h0000});
        step();
        checkOutput("t1_idle", 32'({a_if.gnt, a_if.done, b_if.gnt, b_if.done}), 32'd0);

        // Continuous requests from reset: A,B,A,B every two cycles.
        exp_gnt  = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        exp_done = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        rst = 1'b0;
        applyStimulus(0, 1, 0, 3'd3, 3'd0, 0, 0);
        applyStimulus(1, 1, 0, 3'd3, 3'd3, 0, 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checkOutput($sformatf("rr_gnt_%0d", i), 32'({a_if.gnt, b_if.gnt}), 32'(exp_gnt[i]));
            checkOutput($sformatf("rr_done_%0d", i), 32'({a_if.done, b_if.done}), 32'(exp_done[i]));
        end
        applyStimulus(0, 0, 0, 3'd3, 3'd0, 0, 0);
        applyStimulus(1, 0, 0, 3'd3, 3'd3, 0, 0);
        step();
        checkOutput("rr_tail_done", 32'({a_if.done, b_if.done}), 32'b01);
        checkOutput("rr_tail_gnt", 32'({a_if.gnt, b_if.gnt}), 32'b00);
        step();

        // B lock: three B operations while A waits, then A held off by the
        // lock alone, then A served once the lock is sampled low.
        b_lock = 1'b1;
        applyStimulus(1, 1, 0, 3'd3, 3'd0, 0, 0);
        step();
        checkOutput("lk_gnt1", 32'({a_if.gnt, b_if.gnt}), 32'b01);
        applyStimulus(0, 1, 0, 3'd3, 3'd0, 0, 0);
        step();
        step();
        checkOutput("lk_gnt2", 32'({a_if.gnt, b_if.gnt}), 32'b01);
        step();
        step();
        checkOutput("lk_gnt3", 32'({a_if.gnt, b_if.gnt}), 32'b01);
        applyStimulus(1, 0, 0, 3'd3, 3'd0, 0, 0);
        step();
        step();
        checkOutput("lk_hold1", 32'({a_if.gnt, b_if.gnt}), 32'b00);
        step();
        checkOutput("lk_hold2", 32'({a_if.gnt, b_if.gnt}), 32'b00);
        b_lock = 1'b0;
        step();
        checkOutput("lk_a_gnt", 32'({a_if.gnt, b_if.gnt}), 32'b10);
        applyStimulus(0, 0, 0, 3'd3, 3'd0, 0, 0);
        step();
        step();
        checkOutput("lk_a_done", 32'(a_if.done), 32'd1);
        step();

        // A writes R5=0xBEEF, B reads R5/R3 in the very next slot.
        applyStimulus(0, 1, 1, 0, 0, 3'd5, 16'hBEEF);
        step();
        checkOutput("raw_a_gnt", 32'(a_if.gnt), 32'd1);
        applyStimulus(0, 0, 1, 0, 0, 3'd5, 16'hBEEF);
        applyStimulus(1, 1, 0, 3'd5, 3'd3, 0, 0);
        step();
        step();
        checkOutput("raw_b_gnt", 32'({a_if.done, b_if.gnt}), 32'b11);
        applyStimulus(1, 0, 0, 3'd5, 3'd3, 0, 0);
        step();
        step();
        checkOutput("raw_b_done", 32'(b_if.done), 32'd1);
        checkOutput("raw_b_rdata", {b_if.rdata1, b_if.rdata2}, {16'hBEEF, 16'h1234});
        checkOutput("raw_a_rdata", {a_if.rdata1, a_if.rdata2}, {16'h1234, 16'h0000});
        step();

        // Reset before the falling edge of a write ISSUE drops the write.
        doOp(0, 1, 0, 0, 3'd2, 16'h0011, "rs_pre");
        applyStimulus(0, 1, 1, 0, 0, 3'd2, 16'h00FF);
        step();
        checkOutput("rs_issue", 32'({a_if.gnt, rf_writeEn}), 32'b11);
        rst = 1'b0;
        #1;
        checkOutput("rs_drop", 32'({a_if.gnt, rf_writeEn, rf_readEn, a_if.done}), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("rs_no_done_%0d", i), 32'({a_if.done, rf_writeEn}), 32'd0);
        end
        checkOutput("rs_rdata_clr", {a_if.rdata1, a_if.rdata2}, 32'd0);
        rst = 1'b1;
        doOp(0, 1, 0, 0, 3'd4, 16'h4444, "rs_w4");
        doOp(0, 1, 0, 0, 3'd6, 16'h6666, "rs_w6");
        doOp(0, 0, 3'd2, 3'd4, 0, 0, "rs_rd");
        checkOutput("rs_r2_kept", {a_if.rdata1, a_if.rdata2}, {16'h0011, 16'h4444});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
